// File: rtl/parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parser_pkg
// Description : Shared definitions for the parser and its transmit-side
//               frame packer (default word width, packer state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package parser_pkg;

  // Default packed word width in bits; must be a multiple of 8.
  localparam int DEFAULT_DATA_WIDTH = 64;

  // Packer accumulator state: empty, partially filled, or holding a
  // completed word that could not yet move to the output registers.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PEND = 2'd2
  } packer_state_e;

endpackage : parser_pkg
`default_nettype wire

// File: rtl/frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : frame_packer
// Description : Packs a valid/ready byte stream little-endian into
//               DATA_WIDTH-bit words with byte count and frame-end flag,
//               presented to the parser with parser_ready backpressure.
//               One accumulator plus one output register stage; a completed
//               word that finds the output busy waits in the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_packer
  import parser_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] data_buffer,
  output logic [IDX_W-1:0]      idx,
  output logic                  last_flag,
  output logic                  data_valid,
  input  logic                  parser_ready,
  output logic [31:0]           frame_cnt
);

  packer_state_e         r_state;
  packer_state_e         w_state_nxt;

  logic [DATA_WIDTH-1:0] r_acc_data;
  logic [IDX_W-1:0]      r_acc_cnt;
  logic [IDX_W-1:0]      r_pend_cnt;
  logic                  r_pend_last;

  logic                  r_s_ready;
  logic [DATA_WIDTH-1:0] r_data_buffer;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_last_flag;
  logic                  r_data_valid;
  logic [31:0]           r_frame_cnt;

  logic                  w_accept;
  logic                  w_complete;
  logic                  w_slot_free;
  logic                  w_xfer;
  logic                  w_load_new;
  logic                  w_load_pend;
  logic                  w_hold;
  logic [IDX_W-1:0]      w_cnt_inc;
  logic [DATA_WIDTH-1:0] w_new_word;

  assign w_accept    = s_valid && r_s_ready;
  assign w_complete  = w_accept && (s_last || (r_acc_cnt == IDX_W'(BYTES - 1)));
  assign w_slot_free = !r_data_valid || parser_ready;
  assign w_xfer      = r_data_valid && parser_ready;
  assign w_cnt_inc   = r_acc_cnt + IDX_W'(1);

  // Accumulator contents with the incoming byte merged into lane acc_cnt.
  always_comb begin
    w_new_word = r_acc_data;
    for (int k = 0; k < BYTES; k++) begin
      if (r_acc_cnt == IDX_W'(k)) begin
        w_new_word[8*k +: 8] = s_data;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a completing byte either empties the accumulator (slot
  // free) or parks the word in it (slot busy); a parked word leaves as soon
  // as the output slot frees up.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, FILL: begin
        if (w_complete) begin
          w_state_nxt = w_slot_free ? IDLE : PEND;
        end else if (w_accept) begin
          w_state_nxt = FILL;
        end
      end
      PEND: begin
        if (w_slot_free) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode: which word (if any) loads into the output stage.
  always_comb begin
    w_load_new  = 1'b0;
    w_load_pend = 1'b0;
    w_hold      = 1'b0;
    case (r_state)
      IDLE, FILL: begin
        w_load_new = w_complete && w_slot_free;
        w_hold     = w_complete && !w_slot_free;
      end
      PEND: begin
        w_load_pend = w_slot_free;
      end
      default: ;
    endcase
  end

  // Accumulator: collect bytes, park a completed word, or clear when a word
  // moves to the output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_data  <= '0;
      r_acc_cnt   <= '0;
      r_pend_cnt  <= '0;
      r_pend_last <= 1'b0;
    end else if (w_load_new || w_load_pend) begin
      r_acc_data <= '0;
      r_acc_cnt  <= '0;
    end else if (w_hold) begin
      r_acc_data  <= w_new_word;
      r_acc_cnt   <= '0;
      r_pend_cnt  <= w_cnt_inc;
      r_pend_last <= s_last;
    end else if (w_accept) begin
      r_acc_data <= w_new_word;
      r_acc_cnt  <= w_cnt_inc;
    end
  end

  // Output stage: load a new or parked word, clear after transfer, hold
  // steady while stalled. s_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_ready     <= 1'b1;
      r_data_valid  <= 1'b0;
      r_data_buffer <= '0;
      r_idx         <= '0;
      r_last_flag   <= 1'b0;
    end else begin
      r_s_ready <= (w_state_nxt != PEND);
      if (w_load_new) begin
        r_data_valid  <= 1'b1;
        r_data_buffer <= w_new_word;
        r_idx         <= w_cnt_inc;
        r_last_flag   <= s_last;
      end else if (w_load_pend) begin
        r_data_valid  <= 1'b1;
        r_data_buffer <= r_acc_data;
        r_idx         <= r_pend_cnt;
        r_last_flag   <= r_pend_last;
      end else if (w_xfer) begin
        r_data_valid  <= 1'b0;
        r_data_buffer <= '0;
        r_idx         <= '0;
        r_last_flag   <= 1'b0;
      end
    end
  end

  // Delivered-frame counter: bumps when a frame's final word is handshaken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_xfer && r_last_flag) begin
      r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  assign s_ready     = r_s_ready;
  assign data_valid  = r_data_valid;
  assign data_buffer = r_data_buffer;
  assign idx         = r_idx;
  assign last_flag   = r_last_flag;
  assign frame_cnt   = r_frame_cnt;

endmodule : frame_packer
`default_nettype wire
